// File: rtl/flow_led_pkg.sv
// flow_led_pkg: shared FSM encoding, default widths and active-low one-hot check
package flow_led_pkg;
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;
  localparam int N_DEF = 8;
  localparam int PW_DEF = $clog2(N_DEF);
  function automatic logic onehot_lo_valid(input logic [63:0] v, input int n);
    int z;
    z = 0;
    for (int i = 0; i < 64; i++) if (i < n && !v[i]) z++;
    return z == 1;
  endfunction
endpackage

// File: rtl/flow_led_decoder_decode.sv
// onehot_lo_decode: active-low one-hot to index, lowest zero wins, valid only for a single zero
module onehot_lo_decode
  import flow_led_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  led,
  output logic          valid,
  output logic [PW-1:0] idx
);
  always_comb begin
    valid = onehot_lo_valid(64'(led), N);
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (!led[i]) idx = PW'(i);
  end
endmodule

// File: rtl/flow_led_decoder.sv
// flow_led_decoder: locks onto a running-light sequence, counts laps and faults.
// Define FLOW_DEC_BIDIR_EN to also accept descending sequences (dir output).
module flow_led_decoder
  import flow_led_pkg::*;
#(
  parameter int N        = 8,
  parameter int LOCK_CNT = 3,
  parameter int CNT_W    = 8,
  localparam int PW      = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [N-1:0]     led_in,
  output logic [PW-1:0]    pos,
  output logic             pos_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] lap_count,
  output logic             dir
);
`ifdef FLOW_DEC_BIDIR_EN
  localparam logic BIDIR = 1'b1;
`else
  localparam logic BIDIR = 1'b0;
`endif
  state_t state_q, state_d;
  logic [PW-1:0] pos_q, pos_d, idx;
  logic [3:0] match_q, match_d;
  logic [CNT_W-1:0] err_count_q, err_count_d, lap_count_q, lap_count_d;
  logic pos_valid_q, pos_valid_d, err_pulse_q, err_pulse_d, dir_q, dir_d;
  logic valid, hold, fwd, bwd, legal, sdir, wrap, fault;
  onehot_lo_decode #(.N(N), .PW(PW)) u_dec (.led(led_in), .valid(valid), .idx(idx));
  assign hold  = idx == pos_q;
  assign fwd   = idx == PW'(pos_q + 1'b1);
  assign bwd   = idx == PW'(pos_q - 1'b1);
  assign sdir  = BIDIR & bwd;
  assign legal = fwd | sdir;
  assign wrap  = dir_q ? pos_q == '0 : pos_q == PW'(N - 1);
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    pos_valid_d = pos_valid_q;
    match_d = match_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    lap_count_d = lap_count_q;
    dir_d = dir_q;
    fault = 1'b0;
    if (sample_en) begin
      if (state_q == HUNT) begin
        pos_valid_d = valid;
        if (valid) begin
          pos_d = idx;
          match_d = '0;
          state_d = VERIFY;
        end
      end else if (!valid) begin
        pos_valid_d = 1'b0;
        match_d = '0;
        state_d = HUNT;
        fault = state_q == LOCKED;
      end else if (hold) begin
        pos_valid_d = 1'b1;
      end else if (state_q == VERIFY) begin
        pos_valid_d = 1'b1;
        pos_d = idx;
        if (!legal) match_d = '0;
        else if (match_q != '0 && sdir != dir_q) begin
          match_d = '0;
          dir_d = sdir;
        end else begin
          match_d = match_q + 1'b1;
          dir_d = sdir;
          if (match_d == 4'(LOCK_CNT)) state_d = LOCKED;
        end
      end else begin
        pos_valid_d = 1'b1;
        pos_d = idx;
        if (legal && sdir == dir_q) lap_count_d = wrap ? lap_count_q + 1'b1 : lap_count_q;
        else fault = 1'b1;
      end
      // a fault drops lock and suppresses any lap credit from the same sample
      if (fault) begin
        err_pulse_d = 1'b1;
        err_count_d = &err_count_q ? err_count_q : err_count_q + 1'b1;
        lap_count_d = lap_count_q;
        match_d = '0;
        state_d = HUNT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HUNT;
      pos_q <= '0;
      pos_valid_q <= 1'b0;
      match_q <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      lap_count_q <= '0;
      dir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      pos_valid_q <= pos_valid_d;
      match_q <= match_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      lap_count_q <= lap_count_d;
      dir_q <= dir_d;
    end
  end
  assign pos = pos_q;
  assign pos_valid = pos_valid_q;
  assign locked = state_q == LOCKED;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign lap_count = lap_count_q;
  assign dir = BIDIR & dir_q;
endmodule

// File: tb/tb_flow_led_decoder.sv
// tb_flow_led_decoder: scoreboard bench for the default (unidirectional) build
module tb_flow_led_decoder;
  typedef struct packed {
    logic [2:0] pos;
    logic       pv;
    logic       lk;
    logic       ep;
    logic [7:0] ec;
    logic [7:0] lc;
    logic       dir;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0, sample_en = 1'b0;
  logic [7:0] led_in = 8'hFF;
  logic [2:0] pos;
  logic pos_valid, locked, err_pulse, dir;
  logic [7:0] err_count, lap_count;
  exp_t q[$];
  exp_t e, act;
  bit mon_tk;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  flow_led_decoder dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .led_in(led_in),
    .pos(pos), .pos_valid(pos_valid), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .lap_count(lap_count), .dir(dir)
  );
  function automatic exp_t E(input int p, input int pv, input int lk, input int ep, input int ec, input int lc);
    exp_t r;
    r.pos = 3'(p);
    r.pv = 1'(pv);
    r.lk = 1'(lk);
    r.ep = 1'(ep);
    r.ec = 8'(ec);
    r.lc = 8'(lc);
    r.dir = 1'b0;
    return r;
  endfunction
  task automatic step(input logic rn, input logic se, input logic [7:0] v, input exp_t x);
    @(negedge clk);
    reset = rn;
    sample_en = se;
    led_in = v;
    if (!rn || se) q.push_back(x);
  endtask
  task automatic smp(input logic [7:0] v, input exp_t x);
    step(1'b1, 1'b1, v, x);
  endtask
  task automatic idle();
    step(1'b1, 1'b0, 8'hFF, E(0, 0, 0, 0, 0, 0));
  endtask
  task automatic lock(input int ec, input int lc);
    smp(8'hFE, E(0, 1, 0, 0, ec, lc));
    smp(8'hFD, E(1, 1, 0, 0, ec, lc));
    smp(8'hFB, E(2, 1, 0, 0, ec, lc));
    smp(8'hF7, E(3, 1, 1, 0, ec, lc));
  endtask
  always @(posedge clk) begin
    mon_tk = sample_en || !reset;
    #1;
    checks++;
    if (mon_tk) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: DUT presented a result with no expectation queued");
      end else begin
        e = q.pop_front();
        act = {pos, pos_valid, locked, err_pulse, err_count, lap_count, dir};
        if (act !== e)
          begin
            errors++;
            $display("FAIL outputs: got pos=%0d pv=%b lk=%b ep=%b ec=%0d lc=%0d dir=%b, want pos=%0d pv=%b lk=%b ep=%b ec=%0d lc=%0d dir=%b",
                     act.pos, act.pv, act.lk, act.ep, act.ec, act.lc, act.dir,
                     e.pos, e.pv, e.lk, e.ep, e.ec, e.lc, e.dir);
          end
      end
    end else if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL idle_err_pulse: got %b want 0", err_pulse);
    end
  end
  initial begin
    q.push_back(E(0, 0, 0, 0, 0, 0));
    lock(0, 0);
    smp(8'hF7, E(3, 1, 1, 0, 0, 0));
    idle();
    smp(8'hEF, E(4, 1, 1, 0, 0, 0));
    smp(8'hDF, E(5, 1, 1, 0, 0, 0));
    smp(8'hBF, E(6, 1, 1, 0, 0, 0));
    smp(8'h7F, E(7, 1, 1, 0, 0, 0));
    smp(8'hFE, E(0, 1, 1, 0, 0, 1));
    smp(8'hFD, E(1, 1, 1, 0, 0, 1));
    smp(8'hFB, E(2, 1, 1, 0, 0, 1));
    idle();
    smp(8'hEF, E(4, 1, 0, 1, 1, 1));
    idle();
    smp(8'hDF, E(5, 1, 0, 0, 1, 1));
    smp(8'hFF, E(5, 0, 0, 0, 1, 1));
    smp(8'hFF, E(5, 0, 0, 0, 1, 1));
    lock(1, 1);
    smp(8'hFC, E(3, 0, 0, 1, 2, 1));
    lock(2, 1);
    smp(8'hFF, E(3, 0, 0, 1, 3, 1));
    smp(8'hEF, E(4, 1, 0, 0, 3, 1));
    smp(8'hDF, E(5, 1, 0, 0, 3, 1));
    smp(8'hBF, E(6, 1, 0, 0, 3, 1));
    smp(8'h7F, E(7, 1, 1, 0, 3, 1));
    smp(8'hFD, E(1, 1, 0, 1, 4, 1));
    smp(8'h7F, E(7, 1, 0, 0, 4, 1));
    smp(8'hBF, E(6, 1, 0, 0, 4, 1));
    lock(4, 1);
    step(1'b0, 1'b1, 8'hFB, E(0, 0, 0, 0, 0, 0));
    smp(8'hFD, E(1, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 256; i++) begin
      lock(i - 1 > 255 ? 255 : i - 1, 0);
      smp(8'hFC, E(3, 0, 0, 1, i > 255 ? 255 : i, 0));
    end
    idle();
    idle();
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
